// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The controller takes the slave view; stage-side logic (or a bench) takes the master view.
interface pipeline_ctrl_if;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        ex_stall_req;
    logic        mem_stall_req;
    logic [4:0]  mem_is_exception;
    logic        mem_is_ertn;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        clr_perf;
    logic [5:0]  pause;
    logic        exception_flush;
    logic [31:0] flush_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
        output mem_is_exception, mem_is_ertn, csr_eentry, csr_era, clr_perf,
        input  pause, exception_flush, flush_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
        input  mem_is_exception, mem_is_ertn, csr_eentry, csr_era, clr_perf,
        output pause, exception_flush, flush_pc, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Six-stage pipeline stall/flush controller: stall priority encoding, exception/ertn flush
// sequencing (deferred while mem is stalled), stall watchdog and stall-cycle perf counter.
module pipeline_ctrl #(
    parameter int unsigned Timeout = 1024
) (
    input logic           clk_i,
    input logic           rst_ni,
    pipeline_ctrl_if.slave ctrl_if
);

    localparam logic [15:0] TimeoutCnt = 16'(Timeout);

    typedef enum logic [1:0] {StRun, StWaitMem, StFlush} state_e;

    state_e      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cycles_q, cycles_d;

    logic        exc_req;
    logic [31:0] target;
    logic [5:0]  pause;
    logic        flush;
    logic [31:0] flush_pc;

    function automatic logic [5:0] encode(logic if_r, logic id_r, logic ex_r, logic mem_r);
        if (mem_r)     return 6'b011111;
        else if (ex_r) return 6'b001111;
        else if (id_r) return 6'b000111;
        else if (if_r) return 6'b000011;
        else           return 6'b000000;
    endfunction

    assign exc_req = (ctrl_if.mem_is_exception != 5'd0) | ctrl_if.mem_is_ertn;
    // Exception beats ertn when both are flagged on the same instruction.
    assign target  = (ctrl_if.mem_is_ertn && ctrl_if.mem_is_exception == 5'd0) ?
                     ctrl_if.csr_era : ctrl_if.csr_eentry;

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pause     = 6'b000000;
        flush     = 1'b0;
        flush_pc  = 32'd0;
        unique case (state_q)
            StRun: begin
                if (exc_req && !ctrl_if.mem_stall_req) begin
                    flush    = 1'b1;
                    flush_pc = target;
                    state_d  = StFlush;
                end else if (exc_req) begin
                    pend_pc_d = target;
                    pause     = 6'b011111;
                    state_d   = StWaitMem;
                end else begin
                    pause = encode(ctrl_if.if_stall_req, ctrl_if.id_stall_req,
                                   ctrl_if.ex_stall_req, ctrl_if.mem_stall_req);
                end
            end
            StWaitMem: begin
                if (ctrl_if.mem_stall_req) begin
                    pause = 6'b011111;
                end else begin
                    flush    = 1'b1;
                    flush_pc = pend_pc_q;
                    state_d  = StFlush;
                end
            end
            StFlush: begin
                // Mem register holds a bubble now, so its stall and exception flags are stale.
                pause   = encode(ctrl_if.if_stall_req, ctrl_if.id_stall_req,
                                 ctrl_if.ex_stall_req, 1'b0);
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        wd_d = 16'd0;
        if (pause != 6'd0) begin
            wd_d = (wd_q < TimeoutCnt) ? wd_q + 16'd1 : wd_q;
        end
        timeout_d = timeout_q | (wd_d == TimeoutCnt);

        cycles_d = cycles_q;
        if (ctrl_if.clr_perf) begin
            cycles_d = 32'd0;
        end else if (pause[0] && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRun;
            pend_pc_q <= 32'd0;
            wd_q      <= 16'd0;
            timeout_q <= 1'b0;
            cycles_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

    assign ctrl_if.pause           = rst_ni ? pause : 6'd0;
    assign ctrl_if.exception_flush = rst_ni & flush;
    assign ctrl_if.flush_pc        = rst_ni ? flush_pc : 32'd0;
    assign ctrl_if.stall_timeout   = timeout_q;
    assign ctrl_if.stall_cycles    = cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table for single-cycle behaviour plus
// hand-written multi-cycle sequences; expected combinational outputs flow through a queue.
module tb_pipeline_ctrl;

    logic clk;
    logic rst_n;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.Timeout(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctrl_if(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;     // {mem, ex, id, if}
        logic [4:0]  exc;
        logic        ertn;
        logic [31:0] eentry;
        logic [31:0] era;
        logic [5:0]  pause;
        logic        flush;
        logic [31:0] fpc;
    } vec_t;

    typedef struct {
        logic [5:0]  pause;
        logic        flush;
        logic [31:0] fpc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".pause"}, 32'(bus.pause), 32'(e.pause));
            check({tag, ".flush"}, 32'(bus.exception_flush), 32'(e.flush));
            check({tag, ".flush_pc"}, bus.flush_pc, e.fpc);
        end
    endtask

    // Drive at negedge, compare combinational outputs mid-cycle, return just after posedge.
    task automatic apply(input string tag, input logic [3:0] req, input logic [4:0] exc,
                         input logic ertn, input logic [31:0] ee, input logic [31:0] era,
                         input logic [5:0] ep, input logic ef, input logic [31:0] epc);
        exp_t e;
        @(negedge clk);
        bus.if_stall_req     = req[0];
        bus.id_stall_req     = req[1];
        bus.ex_stall_req     = req[2];
        bus.mem_stall_req    = req[3];
        bus.mem_is_exception = exc;
        bus.mem_is_ertn      = ertn;
        bus.csr_eentry       = ee;
        bus.csr_era          = era;
        e.pause = ep;
        e.flush = ef;
        e.fpc   = epc;
        sb.push_back(e);
        #2 sample(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        apply(tag, 4'b0000, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000000, 1'b0, 32'd0);
    endtask

    initial begin
        tbl[0] = '{4'b0000, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000000, 1'b0, 32'd0};
        tbl[1] = '{4'b0001, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000011, 1'b0, 32'd0};
        tbl[2] = '{4'b0110, 5'd0, 1'b0, 32'd0, 32'd0, 6'b001111, 1'b0, 32'd0};
        tbl[3] = '{4'b1110, 5'd0, 1'b0, 32'd0, 32'd0, 6'b011111, 1'b0, 32'd0};
        tbl[4] = '{4'b0010, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000111, 1'b0, 32'd0};
        tbl[5] = '{4'b1111, 5'd0, 1'b0, 32'd0, 32'd0, 6'b011111, 1'b0, 32'd0};
        tbl[6] = '{4'b0010, 5'b00100, 1'b0, 32'h1C00_8000, 32'h1C00_0124,
                   6'b000000, 1'b1, 32'h1C00_8000};
        tbl[7] = '{4'b0000, 5'd0, 1'b1, 32'h1C00_8000, 32'h1C00_0124,
                   6'b000000, 1'b1, 32'h1C00_0124};
        tbl[8] = '{4'b0000, 5'b00001, 1'b1, 32'h1C00_9000, 32'h1C00_0124,
                   6'b000000, 1'b1, 32'h1C00_9000};
        tbl[9] = '{4'b0101, 5'b10000, 1'b0, 32'hDEAD_0040, 32'h0000_1234,
                   6'b000000, 1'b1, 32'hDEAD_0040};

        bus.if_stall_req     = 1'b0;
        bus.id_stall_req     = 1'b0;
        bus.ex_stall_req     = 1'b0;
        bus.mem_stall_req    = 1'b1;
        bus.mem_is_exception = 5'b00010;
        bus.mem_is_ertn      = 1'b0;
        bus.csr_eentry       = 32'h1C00_8000;
        bus.csr_era          = 32'd0;
        bus.clr_perf         = 1'b0;
        rst_n                = 1'b0;

        // Reset forces outputs even with requests asserted.
        #2;
        check("rst.pause", 32'(bus.pause), 32'd0);
        check("rst.flush", 32'(bus.exception_flush), 32'd0);
        check("rst.flush_pc", bus.flush_pc, 32'd0);
        check("rst.timeout", 32'(bus.stall_timeout), 32'd0);
        check("rst.cycles", bus.stall_cycles, 32'd0);

        @(negedge clk);
        bus.mem_stall_req    = 1'b0;
        bus.mem_is_exception = 5'd0;
        rst_n                = 1'b1;

        // Watchdog (Timeout = 4): 3 stalls + 1 idle must not trip it.
        for (int i = 0; i < 3; i++)
            apply("wd_a", 4'b0001, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000011, 1'b0, 32'd0);
        idle("wd_gap");
        check("wd.after_3", 32'(bus.stall_timeout), 32'd0);
        for (int i = 0; i < 3; i++)
            apply("wd_b", 4'b0001, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000011, 1'b0, 32'd0);
        check("wd.after_3b", 32'(bus.stall_timeout), 32'd0);
        apply("wd_b4", 4'b0001, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000011, 1'b0, 32'd0);
        idle("wd_end");
        check("wd.tripped", 32'(bus.stall_timeout), 32'd1);
        check("perf.seven", bus.stall_cycles, 32'd7);
        idle("wd_sticky");
        check("wd.sticky", 32'(bus.stall_timeout), 32'd1);

        bus.clr_perf = 1'b1;
        apply("clr", 4'b0001, 5'd0, 1'b0, 32'd0, 32'd0, 6'b000011, 1'b0, 32'd0);
        check("perf.clr_wins", bus.stall_cycles, 32'd0);
        bus.clr_perf = 1'b0;
        apply("perf_inc", 4'b0100, 5'd0, 1'b0, 32'd0, 32'd0, 6'b001111, 1'b0, 32'd0);
        check("perf.one", bus.stall_cycles, 32'd1);

        // Table vectors, each followed by an idle cycle so the next starts in RUN.
        for (int i = 0; i < 10; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].req, tbl[i].exc, tbl[i].ertn, tbl[i].eentry,
                  tbl[i].era, tbl[i].pause, tbl[i].flush, tbl[i].fpc);
            idle($sformatf("vec%0d_idle", i));
        end

        // Immediate flush, then shadow cycle: flags still high, mem stall masked.
        apply("imm", 4'b0000, 5'b00100, 1'b0, 32'h1C00_8000, 32'd0, 6'b000000, 1'b1,
              32'h1C00_8000);
        apply("imm_shadow", 4'b1010, 5'b00100, 1'b0, 32'h1C00_8000, 32'd0, 6'b000111, 1'b0,
              32'd0);
        idle("imm_idle");

        // Deferred flush: 3 stalled cycles, eentry changes mid-wait.
        apply("def0", 4'b1000, 5'b00100, 1'b0, 32'h1C00_8000, 32'd0, 6'b011111, 1'b0, 32'd0);
        apply("def1", 4'b1011, 5'b00100, 1'b0, 32'h0000_0000, 32'd0, 6'b011111, 1'b0, 32'd0);
        apply("def2", 4'b1000, 5'b00100, 1'b0, 32'h0000_0000, 32'd0, 6'b011111, 1'b0, 32'd0);
        apply("def_flush", 4'b0000, 5'b00100, 1'b0, 32'h0000_0000, 32'd0, 6'b000000, 1'b1,
              32'h1C00_8000);
        apply("def_shadow", 4'b0000, 5'b00100, 1'b0, 32'h0000_0000, 32'd0, 6'b000000, 1'b0,
              32'd0);
        idle("def_idle");

        // Async reset while waiting on mem.
        apply("rw_enter", 4'b1000, 5'b00001, 1'b0, 32'h1C00_A000, 32'd0, 6'b011111, 1'b0,
              32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("arst.pause", 32'(bus.pause), 32'd0);
        check("arst.flush", 32'(bus.exception_flush), 32'd0);
        check("arst.flush_pc", bus.flush_pc, 32'd0);
        check("arst.timeout", 32'(bus.stall_timeout), 32'd0);
        check("arst.cycles", bus.stall_cycles, 32'd0);
        @(negedge clk);
        bus.mem_stall_req    = 1'b0;
        bus.mem_is_exception = 5'd0;
        rst_n                = 1'b1;
        for (int i = 0; i < 3; i++) idle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the six-stage pipeline (pc, if, id, ex, mem, wb). It merges per-stage stall requests into the `pause[5:0]` vector consumed by every inter-stage register, including the ex→mem register. It also sequences exception and ertn flushes. If an exception arrives while the mem stage is stalled, the block holds it until the memory access drains, then drives `exception_flush` for one cycle along with the redirect PC. The block also keeps a stall watchdog and a stall-cycle performance counter.

## Interface
- `TIMEOUT`, 1024: consecutive stalled cycles before `stall_timeout` sets. Legal range is 2..65535.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `if_stall_req`  in  1  fetch stage stall request (icache miss).
- `id_stall_req`  in  1  decode stall request (load-use).
- `ex_stall_req`  in  1  execute stall request (multi-cycle mul/div).
- `mem_stall_req`  in  1  mem stage stall request (dcache/bus busy).
- `mem_is_exception`  in  5  per-source exception flags of the instruction in mem. Nonzero means an exception.
- `mem_is_ertn`  in  1  the instruction in mem is ertn.
- `csr_eentry`  in  32  exception entry address.
- `csr_era`  in  32  exception return address.
- `clr_perf`  in  1  synchronous clear of `stall_cycles`.
- `pause`  out  6  stall vector. Bit 0 is pc, bit 5 is wb.
- `exception_flush`  out  1  one-cycle flush of all stage registers.
- `flush_pc`  out  32  redirect target. Valid only while `exception_flush` is 1; otherwise 0.
- `stall_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`  out  32  saturating count of cycles with `pause[0]` set.

## Operation
- **Pause encoding.** The highest requesting stage wins.
  - mem request → 011111
  - ex request → 001111
  - id request → 000111
  - if request → 000011
  - no request → 000000
  - `pause[5]` is never driven to 1.
- **Flush event.** An event is `exc_req` = (`mem_is_exception` != 0) | `mem_is_ertn`.
  - Target is `csr_era` if `mem_is_ertn` and `mem_is_exception` == 0.
  - Otherwise target is `csr_eentry`. An exception takes priority over ertn.
- **FSM states:** RUN, WAIT_MEM, FLUSH.
  - **RUN, `exc_req` & !`mem_stall_req`:**
    - Combinationally assert `exception_flush` = 1 and drive `flush_pc` = target.
    - Force `pause` = 0.
    - Next state is FLUSH.
  - **RUN, `exc_req` & `mem_stall_req`:**
    - Latch target into `pend_pc`.
    - `pause` = 011111; `exception_flush` = 0.
    - Next state is WAIT_MEM.
  - **RUN, otherwise:** normal pause encoding.
  - **WAIT_MEM, `mem_stall_req` = 1:**
    - `pause` = 011111.
    - Mem inputs are ignored; `pend_pc` is not overwritten.
  - **WAIT_MEM, `mem_stall_req` = 0:**
    - Assert `exception_flush` = 1, `flush_pc` = `pend_pc`, `pause` = 0.
    - Next state is FLUSH.
  - **FLUSH:** one-cycle shadow.
    - `exc_req` is ignored, since the mem register now holds a bubble.
    - `pause` uses the normal encoding with `mem_stall_req` masked.
    - `exception_flush` = 0. Next state is RUN.
- **Watchdog.**
  - A 16-bit counter increments on each cycle with `pause` != 0 and clears on any cycle with `pause` == 0.
  - When the counter reaches TIMEOUT, `stall_timeout` is set on the next edge. It stays set until reset.
  - The counter saturates at TIMEOUT.
- **Perf counter.**
  - `stall_cycles` increments on each cycle with `pause[0]` = 1 and saturates at 0xFFFFFFFF.
  - `clr_perf` zeroes it; clear wins over a same-cycle increment.

## Timing
- **Reset (async, `rst` = 0):**
  - State is RUN; `pend_pc` = 0; watchdog = 0.
  - `stall_timeout` = 0; `stall_cycles` = 0.
  - Combinational outputs are forced: `pause` = 0, `exception_flush` = 0, `flush_pc` = 0.
  - Deassertion is synchronized outside this block. The first edge after deassertion evaluates inputs normally.
- **Latencies.**
  - `pause`, `exception_flush` and `flush_pc` are combinational, with zero-cycle latency from requests in RUN.
  - Registered effects appear at the next posedge: stage registers capture the flush or bubble.
  - Flush with mem not stalled: exactly 1 cycle of `exception_flush`.
  - Flush deferred by a mem stall of N cycles: `exception_flush` asserts in the first cycle `mem_stall_req` is 0, N cycles after the event.
  - `exception_flush` is never high on two consecutive cycles.
- **Simultaneous events.**
  - Flush overrides all stall requests in the flush cycle.
  - `if`/`id`/`ex` requests during WAIT_MEM are subsumed by 011111.
- **Reset mid-operation.** Reset in WAIT_MEM discards `pend_pc`; no flush is emitted after reset.
- **Watchdog boundary.** With TIMEOUT = T, T-1 stalled cycles followed by one unstalled cycle leaves `stall_timeout` = 0.

## Test plan
- **Stall priority.** `id_stall_req` = 1 and `ex_stall_req` = 1 → `pause` = 001111. Then `mem_stall_req` = 1 → `pause` = 011111. All requests dropped → 000000.
- **Immediate exception.** `mem_is_exception` = 5'b00100, `csr_eentry` = 0x1C008000, no mem stall → same cycle `exception_flush` = 1, `flush_pc` = 0x1C008000, `pause` = 0. Next cycle `exception_flush` = 0 even though exception flags are still high.
- **Deferred flush.** Exception with `mem_stall_req` high for 3 cycles, and `csr_eentry` changed to 0x0 during the wait → `pause` = 011111 for 3 cycles. Then one cycle of `exception_flush` with `flush_pc` = the original eentry.
- **ertn vs exception.**
  - `mem_is_ertn` = 1, `csr_era` = 0x1C000124 → `flush_pc` = 0x1C000124.
  - `mem_is_ertn` = 1 and `mem_is_exception` = 1 → `flush_pc` = `csr_eentry`.
- **Watchdog and perf counter (TIMEOUT = 4).**
  - `if_stall_req` high 3 cycles, low 1 cycle, high 4 cycles → `stall_timeout` rises only after the 4th consecutive cycle and stays set.
  - `stall_cycles` = 7.
  - `clr_perf` together with a stall → `stall_cycles` = 0.
- **Async reset in WAIT_MEM.** Assert `rst` = 0 mid-clock → all outputs 0 immediately. After release with `mem_stall_req` = 0, no `exception_flush` is emitted.
